// File: rtl/arb3_rr_ctrl.sv
// Three-requester round-robin arbiter with a registered one-hot grant and a registered idle (NOR) flag.
// Optional hold-timeout pre-emption is enabled by defining ARB_TIMEOUT_EN.
module arb3_rr_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       NOREQ,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } stateT;

  localparam logic [HOLD_W-1:0] HoldSat = '1;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((1 << HOLD_W) <= MAX_HOLD)) begin : gBadParams
    $error("arb3_rr_ctrl: MAX_HOLD must be 2..255 and below 2**HOLD_W");
  end

  stateT             stateQ, stateD;
  logic [2:0]        gntQ, gntD;
  logic [1:0]        lastQ, lastD;
  logic [HOLD_W-1:0] holdQ, holdD;
  logic              noreqQ;
  logic              timeoutQ, timeoutD;
  logic [1:0]        winner;
  logic [1:0]        gntId;
  logic              ownerReq;

  // Rotating priority: scan from the requester after the last winner.
  always_comb begin
    winner = 2'd0;
    case (lastQ)
      2'd0:    winner = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
      2'd1:    winner = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
      default: winner = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    gntId = 2'b11;
    case (gntQ)
      3'b001:  gntId = 2'd0;
      3'b010:  gntId = 2'd1;
      3'b100:  gntId = 2'd2;
      default: gntId = 2'b11;
    endcase
  end

  assign ownerReq = |(REQ & gntQ);

  always_comb begin
    stateD   = stateQ;
    gntD     = gntQ;
    lastD    = lastQ;
    holdD    = holdQ;
    timeoutD = 1'b0;
    case (stateQ)
      StIdle: begin
        if (|REQ) begin
          gntD   = 3'b001 << winner;
          lastD  = winner;
          holdD  = HOLD_W'(1);
          stateD = StGrant;
        end
      end
      StGrant: begin
        if (!ownerReq) begin
          gntD   = 3'b000;
          stateD = StGap;
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting at the limit: pre-empt, keep LAST so the others win next.
        else if (holdQ == HOLD_W'(MAX_HOLD)) begin
          gntD     = 3'b000;
          timeoutD = 1'b1;
          stateD   = StGap;
        end
`endif
        else if (holdQ != HoldSat) begin
          holdD = holdQ + HOLD_W'(1);
        end
      end
      StGap: begin
        gntD   = 3'b000;
        stateD = StIdle;
      end
      default: begin
        gntD   = 3'b000;
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ   <= StIdle;
      gntQ     <= 3'b000;
      lastQ    <= 2'd2;
      holdQ    <= '0;
      noreqQ   <= 1'b1;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      gntQ     <= gntD;
      lastQ    <= lastD;
      holdQ    <= holdD;
      noreqQ   <= ~|REQ;
      timeoutQ <= timeoutD;
    end
  end

  assign GNT     = gntQ;
  assign GNT_ID  = gntId;
  assign BUSY    = |gntQ;
  assign NOREQ   = noreqQ;
  assign TIMEOUT = timeoutQ;

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
// Self-checking bench for arb3_rr_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations (works with or without ARB_TIMEOUT_EN).
module tb_arb3_rr_ctrl;

   localparam int MaxHold = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] gntId;
   logic       busy;
   logic       noreq;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arb3_rr_ctrl #(
      .MAX_HOLD(MaxHold),
      .HOLD_W  (8)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .REQ    (req),
      .GNT    (gnt),
      .GNT_ID (gntId),
      .BUSY   (busy),
      .NOREQ  (noreq),
      .TIMEOUT(timeout)
   );

   // Behavioural model: who owns the resource, how long, and how many dead cycles remain.
   int mOwner = -1;
   int mLast = 2;
   int mHeld = 0;
   int mDead = 0;
   bit mValid = 1'b0;
   bit mNoreq = 1'b1;
   bit mTimeout = 1'b0;

   always @(posedge clk) begin
      int cand;
      if (rst) begin
         mOwner = -1;
         mLast = 2;
         mHeld = 0;
         mDead = 0;
         mNoreq = 1'b1;
         mTimeout = 1'b0;
         mValid = 1'b1;
      end else if (mValid) begin
         mNoreq = (req == 3'b000);
         mTimeout = 1'b0;
         if (mOwner >= 0) begin
            if (!req[mOwner]) begin
               mOwner = -1;
               mDead = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (mHeld == MaxHold) begin
               mOwner = -1;
               mDead = 1;
               mTimeout = 1'b1;
            end
`endif
            else begin
               mHeld = (mHeld < 255) ? mHeld + 1 : 255;
            end
         end else if (mDead > 0) begin
            mDead = mDead - 1;
         end else if (req != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
               cand = (mLast + k) % 3;
               if (req[cand] && mOwner < 0) mOwner = cand;
            end
            mLast = mOwner;
            mHeld = 1;
         end
      end
   end

   // Compare all outputs against an expectation; one FAIL line per wrong field.
   task automatic checkOutput(input string name, input logic [2:0] expGnt, input logic [1:0] expId,
                              input logic expNoreq, input logic expTimeout);
      checks++;
      if (gnt !== expGnt) begin
         errors++;
         $display("[TB] FAIL %s gnt got %b expected %b at %0t", name, gnt, expGnt, $time);
      end
      checks++;
      if (gntId !== expId) begin
         errors++;
         $display("[TB] FAIL %s gnt_id got %0d expected %0d at %0t", name, gntId, expId, $time);
      end
      checks++;
      if (busy !== (|expGnt)) begin
         errors++;
         $display("[TB] FAIL %s busy got %b expected %b at %0t", name, busy, |expGnt, $time);
      end
      checks++;
      if (noreq !== expNoreq) begin
         errors++;
         $display("[TB] FAIL %s noreq got %b expected %b at %0t", name, noreq, expNoreq, $time);
      end
      checks++;
      if (timeout !== expTimeout) begin
         errors++;
         $display("[TB] FAIL %s timeout got %b expected %b at %0t", name, timeout, expTimeout, $time);
      end
   endtask

   // Every cycle after reset has been seen, the DUT must match the model.
   always @(negedge clk) begin
      logic [2:0] eg;
      logic [1:0] eid;
      if (mValid) begin
         eg = (mOwner < 0) ? 3'b000 : 3'(3'b001 << mOwner);
         eid = (mOwner < 0) ? 2'b11 : 2'(mOwner);
         checkOutput("model", eg, eid, mNoreq, mTimeout);
      end
   end

   // Drive inputs now (at a falling edge) and let the given number of rising edges pass.
   task automatic applyStimulus(input logic rstV, input logic [2:0] reqV, input int cycles);
      rst = rstV;
      req = reqV;
      repeat (cycles) @(negedge clk);
   endtask

   int order [4] = '{1, 2, 0, 1};

   initial begin
      $display("[TB] start");
      applyStimulus(1'b1, 3'b111, 2);
      checkOutput("reset", 3'b000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b111, 1);
      checkOutput("first_grant", 3'b001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 1);
      checkOutput("release_gap", 3'b000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b000, 2);

      // Lone requester 1.
      applyStimulus(1'b0, 3'b010, 1);
      checkOutput("single_grant", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b010, 2);
      checkOutput("single_hold", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 1);
      checkOutput("single_gap", 3'b000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b000, 1);
      checkOutput("single_idle", 3'b000, 2'b11, 1'b1, 1'b0);

      // Rotation after release: 1 owns, then 3'b101 pending -> 2 then 0.
      applyStimulus(1'b0, 3'b010, 1);
      checkOutput("rot_owner1", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b101, 2);
      checkOutput("rot_gap2", 3'b000, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b101, 1);
      checkOutput("rot_to2", 3'b100, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b001, 3);
      checkOutput("rot_to0", 3'b001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 3);

      // Full contention: 3-cycle tenures, owner drops its request for one edge.
      for (int t = 0; t < 4; t++) begin
         applyStimulus(1'b0, 3'b111, 1);
         checkOutput("contend_grant", 3'(3'b001 << order[t]), 2'(order[t]), 1'b0, 1'b0);
         applyStimulus(1'b0, 3'b111, 2);
         applyStimulus(1'b0, 3'b111 & ~3'(3'b001 << order[t]), 1);
         checkOutput("contend_gap1", 3'b000, 2'b11, 1'b0, 1'b0);
         applyStimulus(1'b0, 3'b111, 1);
         checkOutput("contend_gap2", 3'b000, 2'b11, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 3'b000, 1);

      // Long hold with two requesters.
      applyStimulus(1'b0, 3'b011, 1);
      checkOutput("hold_grant0", 3'b001, 2'd0, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
      applyStimulus(1'b0, 3'b011, 3);
      checkOutput("hold_at_max", 3'b001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b011, 1);
      checkOutput("timeout0", 3'b000, 2'b11, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'b011, 1);
      checkOutput("timeout_gap", 3'b000, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b011, 1);
      checkOutput("after_timeout1", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b011, 4);
      checkOutput("timeout1", 3'b000, 2'b11, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'b000, 2);
`else
      applyStimulus(1'b0, 3'b011, 20);
      checkOutput("hold_unlimited", 3'b001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 3);
`endif

      // Release on the very cycle the limit is reached is an ordinary release.
      applyStimulus(1'b0, 3'b100, 1);
      checkOutput("edge_grant2", 3'b100, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b100, 3);
      checkOutput("edge_hold", 3'b100, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 1);
      checkOutput("edge_release", 3'b000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b000, 2);

      // Reset in cycle 3 of a tenure; LAST must return to 2.
      applyStimulus(1'b0, 3'b010, 1);
      checkOutput("mid_grant1", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b010, 2);
      applyStimulus(1'b1, 3'b010, 1);
      checkOutput("mid_reset", 3'b000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b110, 1);
      checkOutput("post_reset_prio", 3'b010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
